rf_wb_sched: RTL and testbench
==============================

Name: rf_wb_sched

Overview:
- Writeback scheduler for the single-write-port 32x32 register file; shares the port between two producers.
- Port A is the single-cycle ALU/JAL result path. Port B is the load / multi-cycle result path.
- Arbitrates between A and B, applies load sign/zero extension on the B path, and registers the write toward the RF.
- Keeps a pending-destination scoreboard for issued B operations so the hazard logic can stall dependent instructions.

Parameters:
STARVE_MAX, 3, consecutive cycles B may lose to A before B is forced to win (1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising clk
a_valid  in  1  A has a write request
a_ready  out  1  A request accepted this cycle
a_addr  in  5  A destination register
a_data  in  32  A write data
b_valid  in  1  B has a write request
b_ready  out  1  B request accepted this cycle
b_addr  in  5  B destination register
b_data  in  32  B raw data (load word or multi-cycle result)
b_ext  in  3  B extension mode
iss_valid  in  1  a B-class operation is issued this cycle
iss_addr  in  5  destination of the issued operation
rf_we  out  1  RF write enable (registered)
rf_addr  out  5  RF write address (registered)
rf_wd  out  32  RF write data (registered)
pend_mask  out  32  bit i = 1: register i awaits a B writeback

Behaviour:
- Handshake: a transfer occurs when valid=1 and ready=1 in the same cycle. ready is combinational from valid, starve_cnt and rst.
- Requesters hold valid, addr and data stable until accepted.
- Arbitration, per cycle:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant B if starve_cnt == STARVE_MAX, else grant A.
  - At most one ready is high per cycle. Both readies are 0 while rst=0.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when b_valid=1 and B is not granted.
  - Clears to 0 on a B grant or when b_valid=0.
  - States: NORMAL (cnt < STARVE_MAX, A has priority) and FORCE_B (cnt == STARVE_MAX, B has priority). FORCE_B returns to NORMAL on the B grant.
- Output register (latency 1):
  - On the grant edge, rf_addr and rf_wd load the granted address and formatted data.
  - rf_we = 1 for exactly one cycle per grant.
  - With no grant, rf_we = 0 and rf_addr/rf_wd hold their previous values.
- Writes to register 0 are accepted (ready=1) but produce rf_we = 0.
- b_ext formatting, applied to B only; A data always passes as a full word:
  - 000: word
  - 001: {24{d[7]}, d[7:0]}
  - 010: {24'h0, d[7:0]}
  - 011: {16{d[15]}, d[15:0]}
  - 100: {16'h0, d[15:0]}
  - 101-111: word
- Scoreboard:
  - iss_valid sets pend_mask[iss_addr] on the next edge.
  - A B grant clears pend_mask[b_addr] on the grant edge.
  - Set and clear of the same bit in one cycle: the set wins (re-issue).
  - Set of an already-set bit: no change.
  - pend_mask[0] is always 0.
  - A grants never touch pend_mask.
- Reset (rst=0 at an edge), including mid-operation:
  - rf_we=0, rf_addr=0, rf_wd=0, pend_mask=0, starve_cnt=0.
  - Any granted-but-not-yet-written result is dropped.
  - a_ready=b_ready=0 during reset.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: every cycle with rf_we=1 prints "r[%2d] = 0x%8X," with rf_addr and rf_wd, plus a source tag " A" or " B". The print happens in simulation only.
- Not defined: no display statements are compiled. Functional behaviour is identical in both cases.

Test Plan:
- Reset: hold rst=0 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_we=0, pend_mask=0. Release -> A granted first.
- Solo A: a_valid=1, a_addr=5, a_data=32'h1234_5678 -> a_ready=1. Next cycle rf_we=1, rf_addr=5, rf_wd=32'h1234_5678. Following cycle rf_we=0.
- Extension: B writes b_data=32'h0000_80F0 with b_ext=001/010/011/100/000 to r8 -> rf_wd=FFFF_FFF0 / 0000_00F0 / FFFF_80F0 / 0000_80F0 / 0000_80F0.
- Starvation (STARVE_MAX=3): a_valid and b_valid held high continuously -> A granted 3 cycles, B granted on cycle 4 (starve_cnt back to 0), then A again.
- Scoreboard: iss_valid with iss_addr=9 -> pend_mask=0x0000_0200. A B grant to r9 in the same cycle as iss_addr=9 -> bit 9 stays 1. A later B grant to r9 -> pend_mask=0.
- r0 and reset mid-write: B to r0 -> b_ready=1, rf_we=0, pend_mask[0]=0. A grant, then rst=0 on the next edge -> rf_we=0, rf_wd=0.

Source files
------------

// File: rtl/rf_wb_sched.sv
// Writeback scheduler: arbitrates ALU (A) and load/multi-cycle (B) results onto the RF write port.
// Optional WB_TRACE_EN: simulation-only print of every RF write with its source tag.
module rf_wb_sched #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic [2:0]  b_ext,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wd,
    output logic [31:0] pend_mask
);

    // state      | meaning
    // ST_NORMAL  | starve_cnt < STARVE_MAX, A wins when both request
    // ST_FORCE_B | starve_cnt == STARVE_MAX, B wins; left on the B grant
    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_FORCE_B = 1'b1;
    localparam logic [3:0] CNT_MAX    = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [0:0]  state;
    logic        a_grant, b_grant;
    logic [31:0] b_fmt;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_wd_q, rf_wd_d;
    logic [31:0] pend_q, pend_d;

    always_comb begin
        state = (starve_cnt_q == CNT_MAX) ? ST_FORCE_B : ST_NORMAL;
    end

    always_comb begin
        b_grant = rst && b_valid && (!a_valid || (state == ST_FORCE_B));
        a_grant = rst && a_valid && !b_grant;
    end

    assign a_ready = a_grant;
    assign b_ready = b_grant;

    always_comb begin
        case (b_ext)
            3'b001:  b_fmt = {{24{b_data[7]}}, b_data[7:0]};
            3'b010:  b_fmt = {24'h0, b_data[7:0]};
            3'b011:  b_fmt = {{16{b_data[15]}}, b_data[15:0]};
            3'b100:  b_fmt = {16'h0, b_data[15:0]};
            default: b_fmt = b_data;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!b_valid || b_grant) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // r0 writes are consumed but never reach the RF write enable
    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_wd_d   = rf_wd_q;
        if (a_grant) begin
            rf_we_d   = |a_addr;
            rf_addr_d = a_addr;
            rf_wd_d   = a_data;
        end else if (b_grant) begin
            rf_we_d   = |b_addr;
            rf_addr_d = b_addr;
            rf_wd_d   = b_fmt;
        end
    end

    // Set is applied after clear so a same-cycle re-issue keeps the bit pending
    always_comb begin
        pend_d = pend_q;
        if (b_grant) begin
            pend_d[b_addr] = 1'b0;
        end
        if (iss_valid) begin
            pend_d[iss_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= 5'd0;
            rf_wd_q      <= 32'd0;
            pend_q       <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_wd_q      <= rf_wd_d;
            pend_q       <= pend_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_addr   = rf_addr_q;
    assign rf_wd     = rf_wd_q;
    assign pend_mask = pend_q;

`ifdef WB_TRACE_EN
    logic src_b_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_b_q <= 1'b0;
        end else begin
            src_b_q <= b_grant;
        end
    end

    always @(posedge clk) begin
        if (rf_we_q) begin
            $display("r[%2d] = 0x%8X,%s", rf_addr_q, rf_wd_q, src_b_q ? " B" : " A");
        end
    end
`else
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Scoreboard bench for rf_wb_sched: stimulus pushes expected RF writes, a monitor pops them.
module tb_rf_wb_sched;

    logic        clk;
    logic        rst;
    logic        a_valid, a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [2:0]  b_ext;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t w;
    int  n_checks = 0;
    int  n_fail   = 0;

    logic [2:0]  ext_tab[5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    logic [31:0] ext_exp[5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0,
                                32'h0000_80F0, 32'h0000_80F0};
    logic        b_pat[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rf_wb_sched #(.STARVE_MAX(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ext     (b_ext),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wd     (rf_wd),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] addr, input logic [31:0] data);
        if (addr != 5'd0) exp_q.push_back('{addr: addr, data: data});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got r%0d=0x%08h expected no write", rf_addr, rf_wd);
            end else begin
                w = exp_q.pop_front();
                chk("wb_addr", {27'd0, rf_addr}, {27'd0, w.addr});
                chk("wb_data", rf_wd, w.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd1; a_data = 32'hA000_0000;
        b_addr = 5'd2; b_data = 32'h0000_0BBB; b_ext = 3'b000;
        iss_valid = 1'b0; iss_addr = 5'd0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
            chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
            tick();
            chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
            chk("rst_pend", pend_mask, 32'd0);
        end

        // both requesting continuously: A, A, A, B, A
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_data = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            chk("starve_a_ready", {31'd0, a_ready}, {31'd0, !b_pat[i]});
            chk("starve_b_ready", {31'd0, b_ready}, {31'd0, b_pat[i]});
            if (b_pat[i]) push(5'd2, 32'h0000_0BBB);
            else          push(5'd1, a_data);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;

        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234_5678;
        @(negedge clk);
        chk("solo_a_ready", {31'd0, a_ready}, 32'd1);
        chk("solo_b_ready", {31'd0, b_ready}, 32'd0);
        push(5'd5, 32'h1234_5678);
        tick();
        a_valid = 1'b0;
        chk("solo_rf_we", {31'd0, rf_we}, 32'd1);
        tick();
        chk("solo_we_drop", {31'd0, rf_we}, 32'd0);
        chk("solo_addr_hold", {27'd0, rf_addr}, 32'd5);
        chk("solo_wd_hold", rf_wd, 32'h1234_5678);

        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h0000_80F0;
        for (int i = 0; i < 5; i++) begin
            b_ext = ext_tab[i];
            @(negedge clk);
            chk("ext_b_ready", {31'd0, b_ready}, 32'd1);
            push(5'd8, ext_exp[i]);
            tick();
        end
        b_valid = 1'b0; b_ext = 3'b000;

        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        chk("sb_set9", pend_mask, 32'h0000_0200);
        iss_addr = 5'd0;
        tick();
        chk("sb_set0_ignored", pend_mask, 32'h0000_0200);
        iss_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_CAFE;
        @(negedge clk);
        chk("sb_a_ready", {31'd0, a_ready}, 32'd1);
        push(5'd9, 32'h0000_CAFE);
        tick();
        chk("sb_a_no_clear", pend_mask, 32'h0000_0200);
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_1111;
        iss_valid = 1'b1; iss_addr = 5'd9;
        @(negedge clk);
        chk("sb_reissue_ready", {31'd0, b_ready}, 32'd1);
        push(5'd9, 32'h0000_1111);
        tick();
        chk("sb_set_wins", pend_mask, 32'h0000_0200);
        iss_valid = 1'b0; b_data = 32'h0000_2222;
        @(negedge clk);
        chk("sb_clear_ready", {31'd0, b_ready}, 32'd1);
        push(5'd9, 32'h0000_2222);
        tick();
        chk("sb_clear9", pend_mask, 32'h0000_0000);
        b_valid = 1'b0;

        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_DEAD;
        iss_valid = 1'b1; iss_addr = 5'd0;
        @(negedge clk);
        chk("r0_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        chk("r0_rf_we", {31'd0, rf_we}, 32'd0);
        chk("r0_pend", pend_mask, 32'd0);
        b_valid = 1'b0; iss_valid = 1'b0;

        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7777_7777;
        iss_valid = 1'b1; iss_addr = 5'd12;
        @(negedge clk);
        chk("mid_a_ready", {31'd0, a_ready}, 32'd1);
        push(5'd7, 32'h7777_7777);
        tick();
        chk("mid_rf_we", {31'd0, rf_we}, 32'd1);
        chk("mid_pend", pend_mask, 32'h0000_1000);
        iss_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_a_ready", {31'd0, a_ready}, 32'd0);
        tick();
        chk("mid_rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("mid_rst_rf_wd", rf_wd, 32'd0);
        chk("mid_rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        chk("mid_rst_pend", pend_mask, 32'd0);

        rst = 1'b1; a_valid = 1'b0;
        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
